// File: rtl/matrix_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : matrix_result_streamer
// Description : Snapshots the flat N x N product matrix on start and streams
//               its elements out in row-major order over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_result_streamer #(
    parameter int N     = 4,
    parameter int W     = 32,
    parameter int IDX_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [0:N*N*W-1]   mat_in,
    input  logic               start,
    output logic               busy,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [W-1:0]       m_data,
    output logic [IDX_W-1:0]   m_row,
    output logic [IDX_W-1:0]   m_col,
    output logic               m_last,
    output logic               done
);

    localparam logic [0:0]       c_IDLE     = 1'b0;
    localparam logic [0:0]       c_STREAM   = 1'b1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N - 1);

    logic [0:0]         r_state;
    logic [0:N*N*W-1]   r_buf;
    logic [IDX_W-1:0]   r_row;
    logic [IDX_W-1:0]   r_col;
    logic [W-1:0]       r_data;
    logic               r_last;
    logic               r_done;

    logic [0:0]         w_state_nxt;
    logic [IDX_W-1:0]   w_row_nxt;
    logic [IDX_W-1:0]   w_col_nxt;
    logic [W-1:0]       w_data_nxt;
    logic               w_last_nxt;
    logic               w_done_nxt;
    logic               w_capture;

    // Element (0,0) sits at the low-index end; the first bit of a slice is its MSB.
    function automatic logic [W-1:0] elem(input logic [0:N*N*W-1] bus,
                                          input logic [IDX_W-1:0] row,
                                          input logic [IDX_W-1:0] col);
        int base;
        base = W * (N * int'(row) + int'(col));
        return bus[base +: W];
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_data_nxt  = r_data;
        w_last_nxt  = r_last;
        w_done_nxt  = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_STREAM;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_data_nxt  = elem(mat_in, '0, '0);
                    w_last_nxt  = (N == 1);
                end
            end
            c_STREAM: begin
                if (m_ready) begin
                    if (r_last) begin
                        w_state_nxt = c_IDLE;
                        w_row_nxt   = '0;
                        w_col_nxt   = '0;
                        w_data_nxt  = '0;
                        w_last_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        if (r_col == c_LAST_IDX) begin
                            w_col_nxt = '0;
                            w_row_nxt = r_row + IDX_W'(1);
                        end else begin
                            w_col_nxt = r_col + IDX_W'(1);
                        end
                        // Next beat is read from the snapshot, never from the live bus.
                        w_data_nxt = elem(r_buf, w_row_nxt, w_col_nxt);
                        w_last_nxt = (w_row_nxt == c_LAST_IDX) && (w_col_nxt == c_LAST_IDX);
                    end
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_buf   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_data  <= w_data_nxt;
            r_last  <= w_last_nxt;
            r_done  <= w_done_nxt;
            if (w_capture) begin
                r_buf <= mat_in;
            end
        end
    end

    assign busy    = (r_state == c_STREAM);
    assign m_valid = (r_state == c_STREAM);
    assign m_data  = r_data;
    assign m_row   = r_row;
    assign m_col   = r_col;
    assign m_last  = r_last;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_matrix_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_result_streamer
// Description : Self-checking bench; expected beats come from a row-major
//               list of matrix elements kept by the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_result_streamer;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int IDX_W = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [0:N*N*W-1]   mat_in;
    logic               start;
    logic               busy;
    logic               m_valid;
    logic               m_ready;
    logic [W-1:0]       m_data;
    logic [IDX_W-1:0]   m_row;
    logic [IDX_W-1:0]   m_col;
    logic               m_last;
    logic               done;

    logic [0:7]         s_mat_in;
    logic               s_start;
    logic               s_busy;
    logic               s_valid;
    logic               s_ready;
    logic [7:0]         s_data;
    logic [0:0]         s_row;
    logic [0:0]         s_col;
    logic               s_last;
    logic               s_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0]     cur [N*N];
    logic [W-1:0]     got_d [$];
    logic [IDX_W-1:0] got_r [$];
    logic [IDX_W-1:0] got_c [$];
    logic             got_l [$];
    int               ndone;
    int               nglitch;
    bit               timed_out;

    matrix_result_streamer #(.N(N), .W(W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .mat_in(mat_in), .start(start), .busy(busy),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row),
        .m_col(m_col), .m_last(m_last), .done(done)
    );

    matrix_result_streamer #(.N(1), .W(8), .IDX_W(1)) dut1 (
        .clk(clk), .rst(rst), .mat_in(s_mat_in), .start(s_start), .busy(s_busy),
        .m_valid(s_valid), .m_ready(s_ready), .m_data(s_data), .m_row(s_row),
        .m_col(s_col), .m_last(s_last), .done(s_done)
    );

    always #5 clk = ~clk;

    function automatic logic [0:N*N*W-1] flat();
        logic [0:N*N*W-1] b;
        for (int k = 0; k < N*N; k++) b[k*W +: W] = cur[k];
        return b;
    endfunction

    task automatic make_pattern();
        for (int k = 0; k < N*N; k++) cur[k] = W'(16 * (k / N) + (k % N) + 1);
    endtask

    task automatic make_random();
        for (int k = 0; k < N*N; k++) cur[k] = $urandom;
    endtask

    task automatic start_stream(input bit wait_neg);
        if (wait_neg) @(negedge clk);
        mat_in = flat();
        start  = 1'b1;
    endtask

    // Consumer: records every transfer, counts done pulses and stall glitches.
    task automatic consume(input bit rand_ready, input int poke_at, input int tail, input int budget);
        bit stalled = 0;
        bit poked = 0;
        int after = -1;
        logic [W-1:0] h_d = '0;
        logic [IDX_W-1:0] h_r = '0, h_c = '0;
        logic h_l = 0;
        logic rdy;
        got_d.delete(); got_r.delete(); got_c.delete(); got_l.delete();
        ndone = 0; nglitch = 0; timed_out = 1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                ndone++;
                if (after < 0) after = 0;
            end
            if (m_valid) begin
                if (stalled && (m_data !== h_d || m_row !== h_r || m_col !== h_c || m_last !== h_l))
                    nglitch++;
                rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                m_ready = rdy;
                if (rdy) begin
                    got_d.push_back(m_data); got_r.push_back(m_row);
                    got_c.push_back(m_col);  got_l.push_back(m_last);
                end
                stalled = !rdy;
                h_d = m_data; h_r = m_row; h_c = m_col; h_l = m_last;
                if (poke_at >= 0 && !poked && got_d.size() == poke_at) begin
                    mat_in = '1;
                    start  = 1'b1;
                    poked  = 1;
                end
            end else begin
                stalled = 0;
                m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (after >= 0) begin
                if (after == tail) begin
                    timed_out = 0;
                    break;
                end
                after++;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if ({busy, m_valid, m_last, done} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, m_valid, m_last, done});
        end
        n_tests++;
        if ({m_data, m_row, m_col} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h/%0d/%0d expected 0/0/0", m_data, m_row, m_col);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, m_valid, done} !== 3'b0) begin
            n_fail++; $display("FAIL idle_after_reset: got %b expected 000", {busy, m_valid, done});
        end
    endtask

    task automatic test_basic();
        make_pattern();
        m_ready = 1'b1;
        start_stream(1);
        for (int k = 0; k < N*N; k++) begin
            @(negedge clk);
            start = 1'b0;
            n_tests++;
            if ({m_valid, busy, done, m_last, m_row, m_col} !==
                {1'b1, 1'b1, 1'b0, k == N*N-1, IDX_W'(k / N), IDX_W'(k % N)}) begin
                n_fail++;
                $display("FAIL basic_ctrl[%0d]: got v%b b%b d%b l%b r%0d c%0d expected v1 b1 d0 l%b r%0d c%0d",
                         k, m_valid, busy, done, m_last, m_row, m_col, k == N*N-1, k / N, k % N);
            end
            n_tests++;
            if (m_data !== cur[k]) begin
                n_fail++; $display("FAIL basic_data[%0d]: got %0d expected %0d", k, m_data, cur[k]);
            end
        end
        @(negedge clk);
        n_tests++;
        if ({done, m_valid, busy, m_last, m_row, m_col} !== {4'b1000, IDX_W'(0), IDX_W'(0)}) begin
            n_fail++;
            $display("FAIL basic_done: got d%b v%b b%b l%b r%0d c%0d expected d1 v0 b0 l0 r0 c0",
                     done, m_valid, busy, m_last, m_row, m_col);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done);
        end
    endtask

    task automatic test_stall();
        for (int it = 0; it < 3; it++) begin
            if (it == 0) make_pattern(); else make_random();
            start_stream(1);
            consume(1, -1, 3, 600);
            n_tests++;
            if (timed_out || got_d.size() != N*N || ndone != 1 || nglitch != 0) begin
                n_fail++;
                $display("FAIL stall_summary[%0d]: got to%0d beats%0d dones%0d glitches%0d expected to0 beats%0d dones1 glitches0",
                         it, timed_out, got_d.size(), ndone, nglitch, N*N);
            end
            for (int k = 0; k < N*N && k < got_d.size(); k++) begin
                n_tests++;
                if ({got_d[k], got_r[k], got_c[k], got_l[k]} !==
                    {cur[k], IDX_W'(k / N), IDX_W'(k % N), k == N*N-1}) begin
                    n_fail++;
                    $display("FAIL stall_beat[%0d.%0d]: got %h r%0d c%0d l%b expected %h r%0d c%0d l%b",
                             it, k, got_d[k], got_r[k], got_c[k], got_l[k], cur[k], k / N, k % N, k == N*N-1);
                end
            end
        end
    endtask

    task automatic test_ignore_start();
        make_pattern();
        start_stream(1);
        consume(1, 5, 12, 600);
        n_tests++;
        if (timed_out || got_d.size() != N*N || ndone != 1) begin
            n_fail++;
            $display("FAIL busy_start_summary: got to%0d beats%0d dones%0d expected to0 beats%0d dones1",
                     timed_out, got_d.size(), ndone, N*N);
        end
        for (int k = 0; k < N*N && k < got_d.size(); k++) begin
            n_tests++;
            if (got_d[k] !== cur[k]) begin
                n_fail++; $display("FAIL busy_start_beat[%0d]: got %h expected %h", k, got_d[k], cur[k]);
            end
        end
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++; $display("FAIL busy_start_restart: got valid %b expected 0", m_valid);
        end
    endtask

    task automatic test_async_reset();
        make_random();
        m_ready = 1'b1;
        start_stream(1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== cur[7]) begin
            n_fail++; $display("FAIL pre_reset_beat: got v%b %h expected v1 %h", m_valid, m_data, cur[7]);
        end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({m_valid, busy, done, m_last} !== 4'b0 || m_data !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v%b b%b d%b l%b %h expected all 0",
                     m_valid, busy, done, m_last, m_data);
        end
        @(negedge clk);
        rst = 1'b0;
        make_random();
        start_stream(1);
        consume(0, -1, 0, 100);
        n_tests++;
        if (timed_out || got_d.size() != N*N || ndone != 1) begin
            n_fail++;
            $display("FAIL post_reset_summary: got to%0d beats%0d dones%0d expected to0 beats%0d dones1",
                     timed_out, got_d.size(), ndone, N*N);
        end
        for (int k = 0; k < N*N && k < got_d.size(); k++) begin
            n_tests++;
            if ({got_d[k], got_r[k], got_c[k]} !== {cur[k], IDX_W'(k / N), IDX_W'(k % N)}) begin
                n_fail++;
                $display("FAIL post_reset_beat[%0d]: got %h r%0d c%0d expected %h r%0d c%0d",
                         k, got_d[k], got_r[k], got_c[k], cur[k], k / N, k % N);
            end
        end
    endtask

    task automatic test_back_to_back();
        make_random();
        start_stream(1);
        consume(0, -1, 0, 100);
        n_tests++;
        if (timed_out || got_d.size() != N*N || got_d[N*N-1] !== cur[N*N-1] || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: got to%0d beats%0d valid_in_done_cycle %b expected to0 beats%0d valid 0",
                     timed_out, got_d.size(), m_valid, N*N);
        end
        make_random();
        start_stream(0);
        @(negedge clk);
        start   = 1'b0;
        m_ready = 1'b0;
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== cur[0] || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: got v%b d%b %h expected v1 d0 %h", m_valid, done, m_data, cur[0]);
        end
        consume(1, -1, 2, 600);
        n_tests++;
        if (timed_out || got_d.size() != N*N || ndone != 1 || nglitch != 0) begin
            n_fail++;
            $display("FAIL b2b_second: got to%0d beats%0d dones%0d glitches%0d expected to0 beats%0d dones1 glitches0",
                     timed_out, got_d.size(), ndone, nglitch, N*N);
        end
        for (int k = 0; k < N*N && k < got_d.size(); k++) begin
            n_tests++;
            if (got_d[k] !== cur[k]) begin
                n_fail++; $display("FAIL b2b_beat[%0d]: got %h expected %h", k, got_d[k], cur[k]);
            end
        end
    endtask

    task automatic test_n1();
        @(negedge clk);
        s_mat_in = 8'hA5;
        s_ready  = 1'b1;
        s_start  = 1'b1;
        @(negedge clk);
        s_start  = 1'b0;
        s_mat_in = 8'h3C;
        n_tests++;
        if ({s_valid, s_busy, s_last, s_row, s_col, s_done} !== 6'b111000 || s_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL n1_beat: got v%b b%b l%b r%0d c%0d d%b %h expected v1 b1 l1 r0 c0 d0 a5",
                     s_valid, s_busy, s_last, s_row, s_col, s_done, s_data);
        end
        @(negedge clk);
        n_tests++;
        if ({s_done, s_valid, s_busy, s_last} !== 4'b1000) begin
            n_fail++;
            $display("FAIL n1_done: got d%b v%b b%b l%b expected d1 v0 b0 l0", s_done, s_valid, s_busy, s_last);
        end
        @(negedge clk);
        n_tests++;
        if (s_done !== 1'b0) begin
            n_fail++; $display("FAIL n1_done_pulse: got %b expected 0", s_done);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        m_ready  = 1'b0;
        mat_in   = '0;
        s_start  = 1'b0;
        s_ready  = 1'b0;
        s_mat_in = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        test_n1();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
